// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - valid/ready pipelined ALU with LATENCY stages and a completed-op counter
// The ALU result is formed in front of stage 1; later stages only carry it forward.
module pipe_alu #(
  parameter int W_DATA    = 32,
  parameter int LATENCY   = 2,
  parameter int SIGNED_LT = 0,
  parameter int W_CNT     = 16
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [W_DATA-1:0] in_a,
  input  logic [W_DATA-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] out_data,
  output logic              out_flag,
  input  logic              cnt_clr,
  output logic [W_CNT-1:0]  op_count
);

  localparam int W_SH = $clog2(W_DATA);
  localparam int HALF = W_DATA / 2;
  localparam logic [W_DATA-1:0] MOST_NEG = {1'b1, {(W_DATA-1){1'b0}}};

  logic [W_DATA:0]     w_sum;
  logic [W_DATA:0]     w_diff;
  logic [2*W_DATA-1:0] w_shl;
  logic                w_lt;
  logic [W_DATA-1:0]   w_res;
  logic                w_flag;

  assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff = {1'b0, in_a} - {1'b0, in_b};
  // Double-width shift keeps the shifted-out bits in the upper half for the flag.
  assign w_shl  = {{W_DATA{1'b0}}, in_a} << in_b[W_SH-1:0];

  generate
    if (SIGNED_LT != 0) begin : g_lt_signed
      assign w_lt = $signed(in_a) < $signed(in_b);
    end else begin : g_lt_unsigned
      assign w_lt = in_a < in_b;
    end
  endgenerate

  always_comb begin
    w_res  = '0;
    w_flag = 1'b0;
    case (in_op)
      3'd0: begin w_res = w_sum[W_DATA-1:0];  w_flag = w_sum[W_DATA];   end
      3'd1: begin w_res = w_diff[W_DATA-1:0]; w_flag = w_diff[W_DATA];  end
      3'd2: begin w_res = w_shl[W_DATA-1:0];  w_flag = |w_shl[2*W_DATA-1:W_DATA]; end
      3'd3: begin w_res = '0 - in_a;          w_flag = (in_a == MOST_NEG); end
      3'd4: begin w_res = {{(W_DATA-1){1'b0}}, w_lt}; w_flag = w_lt; end
      3'd5: begin w_res = {{(W_DATA-1){1'b0}}, in_a == in_b}; w_flag = (in_a == in_b); end
      3'd6: begin w_res = {in_a[HALF-1:0], in_b[HALF-1:0]}; w_flag = 1'b0; end
      default: begin w_res = '0; w_flag = 1'b1; end
    endcase
  end

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_flag;
  logic [W_DATA-1:0]  r_data [LATENCY];
  logic [LATENCY:0]   w_open;
  logic [LATENCY-1:0] w_adv;

  // w_open[k]: stage k can take new contents this cycle; w_open[LATENCY] is the consumer.
  always_comb begin
    w_open          = '0;
    w_adv           = '0;
    w_open[LATENCY] = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      w_adv[k]  = r_vld[k] && w_open[k+1];
      w_open[k] = !r_vld[k] || w_adv[k];
    end
  end

  assign in_ready  = w_open[0];
  assign out_valid = r_vld[LATENCY-1];
  assign out_data  = r_data[LATENCY-1];
  assign out_flag  = r_flag[LATENCY-1];

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_vld    <= '0;
      r_flag   <= '0;
      op_count <= '0;
      for (int k = 0; k < LATENCY; k++) r_data[k] <= '0;
    end else begin
      if (w_open[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_res;
          r_flag[0] <= w_flag;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_open[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_flag[k] <= r_flag[k-1];
          end
        end
      end
      if (cnt_clr)
        op_count <= '0;
      else if (out_valid && out_ready)
        op_count <= op_count + W_CNT'(1);
    end
  end

endmodule
